// File: rtl/alsu_disp_pkg.sv
// Shared types and constants for the ALSU result display: FSM states,
// widths, active-low segment codes ({g,f,e,d,c,b,a}) and a digit encoder.
package alsu_disp_pkg;

  localparam int unsigned RES_W       = 6;
  localparam int unsigned BCD_W       = 4;
  localparam int unsigned DIGIT_IDX_W = 2;

  typedef enum logic {
    IDLE,
    CONV
  } conv_state_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_of(input logic [BCD_W-1:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = SEG_0;
      4'h1:    s = SEG_1;
      4'h2:    s = SEG_2;
      4'h3:    s = SEG_3;
      4'h4:    s = SEG_4;
      4'h5:    s = SEG_5;
      4'h6:    s = SEG_6;
      4'h7:    s = SEG_7;
      4'h8:    s = SEG_8;
      4'h9:    s = SEG_9;
      4'hA:    s = SEG_A;
      4'hB:    s = SEG_B;
      4'hC:    s = SEG_C;
      4'hD:    s = SEG_D;
      4'hE:    s = SEG_E;
      4'hF:    s = SEG_F;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin2bcd6.sv
// Sequential shift-add-3 (double-dabble) converter: 6-bit binary to two
// BCD digits, one step per clock, six steps per conversion. tens/ones only
// change when a conversion completes, so the display never shows a
// partially shifted value.
module bin2bcd6
  import alsu_disp_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [RES_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] tens,
  output logic [BCD_W-1:0] ones
);

  localparam int unsigned SH_W      = 2 * BCD_W + RES_W;
  localparam logic [2:0]  LAST_STEP = 3'(RES_W - 1);

  conv_state_e      state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [SH_W-1:0]  sh_q, sh_d, adj, shifted;
  logic [BCD_W-1:0] tens_q, tens_d, ones_q, ones_d;

  // Add-3 correction on each BCD nibble, then shift the whole word left.
  always_comb begin
    adj = sh_q;
    if (sh_q[SH_W-1 -: BCD_W] >= BCD_W'(5))
      adj[SH_W-1 -: BCD_W] = sh_q[SH_W-1 -: BCD_W] + BCD_W'(3);
    if (sh_q[RES_W+BCD_W-1 -: BCD_W] >= BCD_W'(5))
      adj[RES_W+BCD_W-1 -: BCD_W] = sh_q[RES_W+BCD_W-1 -: BCD_W] + BCD_W'(3);
    shifted = {adj[SH_W-2:0], 1'b0};
  end

  // Next-state: load on start, shift six times, publish digits on the last step.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    tens_d  = tens_q;
    ones_d  = ones_q;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sh_d    = {{(2 * BCD_W){1'b0}}, bin};
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        sh_d  = shifted;
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == LAST_STEP) begin
          tens_d  = shifted[SH_W-1 -: BCD_W];
          ones_d  = shifted[RES_W+BCD_W-1 -: BCD_W];
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset discards any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      tens_q  <= tens_d;
      ones_q  <= ones_d;
    end
  end

  assign busy = (state_q == CONV);
  assign tens = tens_q;
  assign ones = ones_q;

endmodule

// File: rtl/alsu_seg_display.sv
// ALSU result display: samples the ALSU result/LED buses, converts the
// result to decimal and scans it onto a 4-digit active-low 7-segment display
// (idx0 ones, idx1 tens, idx2 blank, idx3 'E' on invalid op).
// Build option SEG_HEX_EN: show the result in hexadecimal straight from the
// sampled value; the BCD engine is not built and busy stays 0.
module alsu_seg_display
  import alsu_disp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RES_W-1:0] result,
  input  logic [15:0]      leds,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp,
  output logic             err,
  output logic             busy
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [RES_W-1:0]       result_q;
  logic [15:0]            leds_q;
  logic                   leds_nz_prev_q;
  logic                   err_q;
  logic [CNT_W-1:0]       refcnt_q;
  logic [DIGIT_IDX_W-1:0] idx_q;
  logic [3:0]             an_q, an_d;
  logic [6:0]             seg_q, seg_d;
  logic [BCD_W-1:0]       dig0, dig1;

  // Register the ALSU buses; err holds until two consecutive quiet LED samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q       <= '0;
      leds_q         <= '0;
      leds_nz_prev_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      result_q       <= result;
      leds_q         <= leds;
      leds_nz_prev_q <= (leds_q != '0);
      if (leds_q != '0)
        err_q <= 1'b1;
      else if (!leds_nz_prev_q)
        err_q <= 1'b0;
    end
  end

`ifdef SEG_HEX_EN
  assign dig0 = result_q[3:0];
  assign dig1 = {2'b00, result_q[5:4]};
  assign busy = 1'b0;
`else
  logic [RES_W-1:0] conv_src_q, ld_q;
  logic             start, eng_busy, eng_done;
  logic [BCD_W-1:0] tens, ones;

  // A newer result arriving mid-conversion waits: it is re-compared only
  // once the engine is idle again, so nothing in flight is ever aborted.
  assign start = !eng_busy && (result_q != conv_src_q);

  bin2bcd6 u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (result_q),
    .busy  (eng_busy),
    .done  (eng_done),
    .tens  (tens),
    .ones  (ones)
  );

  // Track which value is loaded and which one was last published.
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_q       <= '0;
      conv_src_q <= '0;
    end else begin
      if (start)
        ld_q <= result_q;
      if (eng_done)
        conv_src_q <= ld_q;
    end
  end

  assign dig0 = ones;
  assign dig1 = tens;
  assign busy = eng_busy;
`endif

  // Refresh divider: advance the digit index once every CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      refcnt_q <= '0;
      idx_q    <= '0;
    end else if (refcnt_q == CNT_W'(CLK_DIV - 1)) begin
      refcnt_q <= '0;
      idx_q    <= idx_q + DIGIT_IDX_W'(1);
    end else begin
      refcnt_q <= refcnt_q + CNT_W'(1);
    end
  end

  // Select anode and segment pattern for the current digit slot.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    case (idx_q)
      2'd0: begin an_d = 4'b1110; seg_d = seg_of(dig0); end
      2'd1: begin an_d = 4'b1101; seg_d = seg_of(dig1); end
      2'd2: begin an_d = 4'b1011; seg_d = SEG_BLANK; end
      2'd3: begin an_d = 4'b0111; seg_d = err_q ? SEG_E : SEG_BLANK; end
      default: begin an_d = '1; seg_d = SEG_BLANK; end
    endcase
  end

  // Registered display drive, dark while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= '1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;
  assign err = err_q;

endmodule
